// File: rtl/horner_eval_fsm_if.sv
// Start/operand/result bundle for the Horner polynomial evaluator.
// The master side issues starts and operands; the slave side is the evaluator.
interface horner_eval_fsm_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEGREE = 2
);
  localparam int unsigned CW = (DEGREE + 1) * WIDTH;

  logic             w;
  logic [WIDTH-1:0] x;
  logic [CW-1:0]    coef;
  logic [1:0]       Y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovf;

  modport master (
    output w, x, coef,
    input  Y, busy, done, result, ovf
  );

  modport slave (
    input  w, x, coef,
    output Y, busy, done, result, ovf
  );
endinterface

// File: rtl/horner_eval_fsm.sv
// Multi-cycle unsigned polynomial evaluator using Horner's method:
// one shared multiply step and one shared add step per coefficient.
module horner_eval_fsm #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEGREE = 2
) (
  input  logic                clk,
  input  logic                rst,
  horner_eval_fsm_if.slave    bus
);

  localparam int unsigned CW = (DEGREE + 1) * WIDTH;
  localparam int unsigned W1 = WIDTH + 1;
  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned IW = (DEGREE > 0) ? $clog2(DEGREE + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] x_q, x_n;
  logic [CW-1:0]    coef_q, coef_n;
  logic [WIDTH-1:0] acc_q, acc_n;
  logic [IW-1:0]    idx_q, idx_n;
  logic [WIDTH-1:0] result_q, result_n;
  logic             ovf_q, ovf_n;
  logic             busy_q, done_q;

  logic [W2-1:0]    full;
  logic [W1-1:0]    sum;
  logic [WIDTH-1:0] coef_sel;

  // State and datapath registers; busy/done are registered decodes of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      coef_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      x_q      <= x_n;
      coef_q   <= coef_n;
      acc_q    <= acc_n;
      idx_q    <= idx_n;
      result_q <= result_n;
      ovf_q    <= ovf_n;
      busy_q   <= (state_n == MUL) || (state_n == ADD);
      done_q   <= (state_n == DONE);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_n  = state_q;
    x_n      = x_q;
    coef_n   = coef_q;
    acc_n    = acc_q;
    idx_n    = idx_q;
    result_n = result_q;
    ovf_n    = ovf_q;

    coef_sel = coef_q[32'(idx_q) * WIDTH +: WIDTH];
    full     = W2'(acc_q) * W2'(x_q);
    sum      = W1'(acc_q) + W1'(coef_sel);

    case (state_q)
      IDLE: begin
        if (bus.w) begin
          x_n    = bus.x;
          coef_n = bus.coef;
          acc_n  = bus.coef[DEGREE * WIDTH +: WIDTH];
          ovf_n  = 1'b0;
          if (DEGREE >= 1) begin
            idx_n   = IW'(DEGREE - 1);
            state_n = MUL;
          end else begin
            result_n = bus.coef[WIDTH-1:0];
            state_n  = DONE;
          end
        end
      end
      MUL: begin
        acc_n = full[WIDTH-1:0];
        if (full[W2-1:WIDTH] != '0) ovf_n = 1'b1;
        state_n = ADD;
      end
      ADD: begin
        acc_n = sum[WIDTH-1:0];
        if (sum[WIDTH]) ovf_n = 1'b1;
        if (idx_q == '0) begin
          result_n = sum[WIDTH-1:0];
          state_n  = DONE;
        end else begin
          idx_n   = idx_q - IW'(1);
          state_n = MUL;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.Y      = state_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_horner_eval_fsm.sv
// Randomised self-checking bench for horner_eval_fsm: three instances
// (8-bit/degree 2, 8-bit/degree 0, 16-bit/degree 3) against a polynomial model.
module tb_horner_eval_fsm;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  horner_eval_fsm_if #(.WIDTH(8),  .DEGREE(2)) ifa();
  horner_eval_fsm_if #(.WIDTH(8),  .DEGREE(0)) ifb();
  horner_eval_fsm_if #(.WIDTH(16), .DEGREE(3)) ifc();

  horner_eval_fsm #(.WIDTH(8),  .DEGREE(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  horner_eval_fsm #(.WIDTH(8),  .DEGREE(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  horner_eval_fsm #(.WIDTH(16), .DEGREE(3)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned coef_at(input logic [255:0] cv, input int wd, input int i);
    longint unsigned m;
    m = (64'd1 << wd) - 64'd1;
    return 64'((cv >> (i * wd)) & 256'(m));
  endfunction

  // p(x) mod 2^wd as a plain power sum
  function automatic logic [63:0] ref_poly(input int wd, input int deg,
                                           input longint unsigned xv, input logic [255:0] cv);
    longint unsigned m, pw, s;
    m = (64'd1 << wd) - 64'd1;
    pw = 1;
    s = 0;
    for (int i = 0; i <= deg; i++) begin
      s  = (s + coef_at(cv, wd, i) * pw) & m;
      pw = (pw * xv) & m;
    end
    return s;
  endfunction

  // True if any exact intermediate of the nested form exceeds wd bits
  function automatic bit ref_ovf(input int wd, input int deg,
                                 input longint unsigned xv, input logic [255:0] cv);
    longint unsigned lim, a, p;
    bit o;
    lim = 64'd1 << wd;
    o = 1'b0;
    a = coef_at(cv, wd, deg);
    for (int i = deg - 1; i >= 0; i--) begin
      p = a * xv;
      if (p >= lim) o = 1'b1;
      a = p % lim;
      p = a + coef_at(cv, wd, i);
      if (p >= lim) o = 1'b1;
      a = p % lim;
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One evaluation on the degree-2 instance; operands are scrambled after the start edge
  task automatic eval_a(input logic [7:0] xv, input logic [23:0] cv, input bit hold);
    logic [63:0] er;
    bit eo;
    er = ref_poly(8, 2, 64'(xv), 256'(cv));
    eo = ref_ovf(8, 2, 64'(xv), 256'(cv));
    ifa.w = 1'b1; ifa.x = xv; ifa.coef = cv;
    tick();
    if (!hold) ifa.w = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      ifa.x = 8'($urandom); ifa.coef = 24'($urandom);
      if (k < 5) begin
        check("a_Y_busy", ifa.Y, (k % 2 == 1) ? 64'd1 : 64'd2);
        check("a_busy", ifa.busy, 1);
        check("a_done_early", ifa.done, 0);
      end else begin
        check("a_Y_done", ifa.Y, 3);
        check("a_busy_done", ifa.busy, 0);
        check("a_done", ifa.done, 1);
        check("a_result", ifa.result, er);
        check("a_ovf", ifa.ovf, 64'(eo));
      end
      tick();
    end
    check("a_Y_idle", ifa.Y, 0);
    check("a_done_idle", ifa.done, 0);
    check("a_result_idle", ifa.result, er);
    check("a_ovf_idle", ifa.ovf, 64'(eo));
  endtask

  task automatic eval_b(input logic [7:0] cv);
    ifb.w = 1'b1; ifb.x = 8'($urandom); ifb.coef = cv;
    tick();
    ifb.w = 1'b0; ifb.coef = 8'($urandom);
    check("b_Y_done", ifb.Y, 3);
    check("b_done", ifb.done, 1);
    check("b_busy", ifb.busy, 0);
    check("b_result", ifb.result, 64'(cv));
    check("b_ovf", ifb.ovf, 0);
    tick();
    check("b_Y_idle", ifb.Y, 0);
    check("b_done_idle", ifb.done, 0);
    check("b_result_idle", ifb.result, 64'(cv));
  endtask

  task automatic eval_c(input logic [15:0] xv, input logic [63:0] cv);
    logic [63:0] er;
    bit eo;
    er = ref_poly(16, 3, 64'(xv), 256'(cv));
    eo = ref_ovf(16, 3, 64'(xv), 256'(cv));
    ifc.w = 1'b1; ifc.x = xv; ifc.coef = cv;
    tick();
    ifc.w = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      ifc.x = 16'($urandom); ifc.coef = {$urandom, $urandom};
      if (k < 7) begin
        check("c_Y_busy", ifc.Y, (k % 2 == 1) ? 64'd1 : 64'd2);
        check("c_done_early", ifc.done, 0);
      end else begin
        check("c_Y_done", ifc.Y, 3);
        check("c_done", ifc.done, 1);
        check("c_result", ifc.result, er);
        check("c_ovf", ifc.ovf, 64'(eo));
      end
      tick();
    end
    check("c_Y_idle", ifc.Y, 0);
    check("c_done_idle", ifc.done, 0);
  endtask

  initial begin
    rst = 1'b1;
    ifa.w = 1'b0; ifa.x = '0; ifa.coef = '0;
    ifb.w = 1'b0; ifb.x = '0; ifb.coef = '0;
    ifc.w = 1'b0; ifc.x = '0; ifc.coef = '0;
    #12;
    check("rst_Y", ifa.Y, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_done", ifa.done, 0);
    check("rst_result", ifa.result, 0);
    check("rst_ovf", ifa.ovf, 0);
    check("rst_b_Y", ifb.Y, 0);
    check("rst_c_Y", ifc.Y, 0);
    rst = 1'b0;
    tick();

    // Known-value evaluations, including overflow and its clearing on the next start
    eval_a(8'd4, {8'd2, 8'd3, 8'd1}, 1'b0);
    check("t1_result_45", ifa.result, 45);
    eval_a(8'd16, {8'd2, 8'd3, 8'd1}, 1'b0);
    check("t2_result_49", ifa.result, 49);
    check("t2_ovf_set", ifa.ovf, 1);
    eval_a(8'd4, {8'd2, 8'd3, 8'd1}, 1'b0);
    check("t2_ovf_clr", ifa.ovf, 0);

    // w held high: back-to-back evaluations accepted only from IDLE
    eval_a(8'd4, {8'd2, 8'd3, 8'd1}, 1'b1);
    eval_a(8'($urandom), 24'($urandom), 1'b1);
    eval_a(8'($urandom), 24'($urandom), 1'b0);

    // Idle hold: result and ovf persist, w low keeps the block parked
    begin
      logic [7:0] r0;
      logic       o0;
      r0 = ifa.result; o0 = ifa.ovf;
      for (int k = 0; k < 3; k++) begin
        ifa.x = 8'($urandom); ifa.coef = 24'($urandom);
        tick();
        check("idle_Y", ifa.Y, 0);
        check("idle_result", ifa.result, 64'(r0));
        check("idle_ovf", ifa.ovf, 64'(o0));
      end
    end

    for (int n = 0; n < 30; n++) eval_a(8'($urandom), 24'($urandom), 1'b0);

    // Asynchronous reset between edges while in ADD
    eval_a(8'd7, {8'd9, 8'd9, 8'd9}, 1'b0);
    ifa.w = 1'b1; ifa.x = 8'd16; ifa.coef = {8'd2, 8'd3, 8'd1};
    tick();
    ifa.w = 1'b0;
    tick();
    check("t4_Y_add", ifa.Y, 2);
    #2 rst = 1'b1;
    #1;
    check("t4_Y", ifa.Y, 0);
    check("t4_busy", ifa.busy, 0);
    check("t4_done", ifa.done, 0);
    check("t4_result", ifa.result, 0);
    check("t4_ovf", ifa.ovf, 0);
    tick();
    #3 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t4_Y_after", ifa.Y, 0);
      check("t4_done_after", ifa.done, 0);
    end

    // Degree-0 instance
    eval_b(8'hA5);
    for (int n = 0; n < 5; n++) eval_b(8'($urandom));

    // 16-bit degree-3 instance
    eval_c(16'hFFFF, {4{16'd1}});
    check("t6_result_0", ifc.result, 0);
    check("t6_ovf", ifc.ovf, 1);
    for (int n = 0; n < 15; n++) eval_c(16'($urandom), {$urandom, $urandom});
    eval_c(16'd3, {16'd1, 16'd2, 16'd3, 16'd4});
    check("t6_small_result", ifc.result, 58);
    check("t6_small_ovf", ifc.ovf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
